// File: rtl/pcie_datalink_pkg.sv
// Shared data-link-layer definitions: DLLP type codes, flow-control DLLP view
// and the CRC-16 polynomial used on DLLPs.
package pcie_datalink_pkg;

    localparam logic [3:0] DLLP_INITFC1_P   = 4'h4;
    localparam logic [3:0] DLLP_INITFC1_NP  = 4'h5;
    localparam logic [3:0] DLLP_INITFC1_CPL = 4'h6;
    localparam logic [3:0] DLLP_INITFC2_P   = 4'hC;
    localparam logic [3:0] DLLP_INITFC2_NP  = 4'hD;
    localparam logic [3:0] DLLP_INITFC2_CPL = 4'hE;
    localparam logic [3:0] DLLP_UPDATEFC_P  = 4'h8;
    localparam logic [3:0] DLLP_UPDATEFC_NP = 4'h9;
    localparam logic [3:0] DLLP_UPDATEFC_CPL = 4'hA;

    // Smallest non-infinite header credit a link partner may advertise.
    localparam logic [7:0] HdrMinCredits = 8'd1;

    localparam logic [15:0] DLLP_CRC_POLY = 16'h100B;
    localparam logic [15:0] DLLP_CRC_INIT = 16'hFFFF;

    // Low two bits of every FC type code select the credit class.
    localparam logic [1:0] FC_CLASS_P   = 2'd0;
    localparam logic [1:0] FC_CLASS_NP  = 2'd1;
    localparam logic [1:0] FC_CLASS_CPL = 2'd2;

    typedef struct packed {
        logic [3:0]  kind;
        logic        rsvd;
        logic [2:0]  vc;
        logic [7:0]  hdr_fc;
        logic [11:0] data_fc;
    } dllp_fc_t;

    // body[7:0] is byte0; scale bits (byte1[7:6], byte2[5:4]) are dropped.
    function automatic dllp_fc_t dllp_fc_decode(input logic [31:0] body);
        dllp_fc_t fc;
        fc.kind    = body[7:4];
        fc.rsvd    = body[3];
        fc.vc      = body[2:0];
        fc.hdr_fc  = {body[13:8], body[23:22]};
        fc.data_fc = {body[19:16], body[31:24]};
        return fc;
    endfunction

endpackage

// File: rtl/pcie_datalink_crc.sv
// Combinational DLLP CRC-16 over a 4-byte body: byte0 first, each byte MSB
// first, non-reflected shift register seeded by crc_in_i.
module pcie_datalink_crc
    import pcie_datalink_pkg::*;
(
    input  logic [15:0] crc_in_i,
    input  logic [31:0] data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_v;
    logic        fb;

    always_comb begin
        crc_v = crc_in_i;
        fb    = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int k = 7; k >= 0; k--) begin
                fb    = crc_v[15] ^ data_i[b*8 + k];
                crc_v = {crc_v[14:0], 1'b0} ^ (fb ? DLLP_CRC_POLY : 16'h0000);
            end
        end
        crc_o = crc_v;
    end

endmodule

// File: rtl/pcie_flow_ctrl_rx.sv
// Receive side of PCIe flow-control initialisation: parses InitFC1/InitFC2/
// UpdateFC DLLPs from an AXI-Stream, checks CRC and records VC0 credits.
module pcie_flow_ctrl_rx
    import pcie_datalink_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    input  logic                  fc_init_en_i,
    output logic                  fc1_values_stored_o,
    output logic                  fc2_values_stored_o,
    output logic [7:0]            p_hdr_o,
    output logic [7:0]            np_hdr_o,
    output logic [7:0]            cpl_hdr_o,
    output logic [11:0]           p_data_o,
    output logic [11:0]           np_data_o,
    output logic [11:0]           cpl_data_o,
    output logic                  crc_err_o,
    output logic                  malformed_o
);

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_CRC   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        tready_q;
    logic [31:0] body_q, body_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] crc_calc;
    logic [7:0]  hdr_q  [3];
    logic [7:0]  hdr_d  [3];
    logic [11:0] data_q [3];
    logic [11:0] data_d [3];
    logic [2:0]  rec_q, rec_d;
    logic        fc1_q, fc1_d;
    logic        fc2_q, fc2_d;
    logic        fc2_pend_q, fc2_pend_d;
    logic        crc_err_q, crc_err_d;
    logic        malformed_q, malformed_d;

    logic        hs;
    logic        pkt_ok;
    logic        fc_type_ok;
    logic        init_evt;
    logic        fc2_evt;
    logic [1:0]  fc_class;
    dllp_fc_t    fc;

    // Fields the parser has no use for (CRC-beat keep, spare tuser bits).
    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tkeep, s_axis_tuser[USER_WIDTH-1:1]};

    pcie_datalink_crc u_crc (
        .crc_in_i (DLLP_CRC_INIT),
        .data_i   (s_axis_tdata[31:0]),
        .crc_o    (crc_calc)
    );

    assign hs = s_axis_tvalid & tready_q;

    always_comb begin
        state_d     = state_q;
        body_d      = body_q;
        crc_d       = crc_q;
        crc_err_d   = 1'b0;
        malformed_d = 1'b0;
        pkt_ok      = 1'b0;

        case (state_q)
            ST_HDR: begin
                if (hs) begin
                    if (s_axis_tuser[0]) begin
                        if (s_axis_tlast) begin
                            malformed_d = 1'b1;
                        end else begin
                            body_d  = s_axis_tdata[31:0];
                            crc_d   = crc_calc;
                            state_d = ST_CRC;
                        end
                    end else if (!s_axis_tlast) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_CRC: begin
                if (hs) begin
                    if (s_axis_tlast) begin
                        state_d = ST_HDR;
                        if (s_axis_tdata[15:0] == ~crc_q) begin
                            pkt_ok = 1'b1;
                        end else begin
                            crc_err_d = 1'b1;
                        end
                    end else begin
                        malformed_d = 1'b1;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (hs && s_axis_tlast) begin
                    state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    // Credit bookkeeping: InitFC1/InitFC2 have kind[2]=1, InitFC2/UpdateFC kind[3]=1.
    always_comb begin
        fc         = dllp_fc_decode(body_q);
        fc_class   = fc.kind[1:0];
        fc_type_ok = (fc.vc == 3'd0) && !fc.rsvd && (fc_class != 2'b11)
                     && (fc.kind[3:2] != 2'b00);
        init_evt   = pkt_ok && fc_type_ok && fc.kind[2];
        fc2_evt    = pkt_ok && fc_type_ok && fc.kind[3];

        rec_d = rec_q;
        for (int i = 0; i < 3; i++) begin
            hdr_d[i]  = hdr_q[i];
            data_d[i] = data_q[i];
            if (init_evt && !rec_q[i] && (fc_class == 2'(i))) begin
                hdr_d[i]  = fc.hdr_fc;
                data_d[i] = fc.data_fc;
                rec_d[i]  = 1'b1;
            end
        end

        fc1_d      = fc1_q | (&rec_d);
        fc2_d      = fc2_q | (fc1_q & (fc2_evt | fc2_pend_q));
        // An InitFC2 that itself completes the set promotes to fc2 one cycle later.
        fc2_pend_d = fc2_evt & ~fc1_q & (&rec_d);

        if (!fc_init_en_i) begin
            rec_d      = 3'b000;
            fc1_d      = 1'b0;
            fc2_d      = 1'b0;
            fc2_pend_d = 1'b0;
            for (int i = 0; i < 3; i++) begin
                hdr_d[i]  = 8'd0;
                data_d[i] = 12'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_HDR;
            tready_q    <= 1'b0;
            body_q      <= 32'd0;
            crc_q       <= 16'd0;
            rec_q       <= 3'b000;
            fc1_q       <= 1'b0;
            fc2_q       <= 1'b0;
            fc2_pend_q  <= 1'b0;
            crc_err_q   <= 1'b0;
            malformed_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                hdr_q[i]  <= 8'd0;
                data_q[i] <= 12'd0;
            end
        end else begin
            state_q     <= state_d;
            tready_q    <= 1'b1;
            body_q      <= body_d;
            crc_q       <= crc_d;
            rec_q       <= rec_d;
            fc1_q       <= fc1_d;
            fc2_q       <= fc2_d;
            fc2_pend_q  <= fc2_pend_d;
            crc_err_q   <= crc_err_d;
            malformed_q <= malformed_d;
            for (int i = 0; i < 3; i++) begin
                hdr_q[i]  <= hdr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign s_axis_tready       = tready_q;
    assign fc1_values_stored_o = fc1_q;
    assign fc2_values_stored_o = fc2_q;
    assign p_hdr_o             = hdr_q[FC_CLASS_P];
    assign np_hdr_o            = hdr_q[FC_CLASS_NP];
    assign cpl_hdr_o           = hdr_q[FC_CLASS_CPL];
    assign p_data_o            = data_q[FC_CLASS_P];
    assign np_data_o           = data_q[FC_CLASS_NP];
    assign cpl_data_o          = data_q[FC_CLASS_CPL];
    assign crc_err_o           = crc_err_q;
    assign malformed_o         = malformed_q;

endmodule

// File: tb/tb_pcie_flow_ctrl_rx.sv
// Directed bench for pcie_flow_ctrl_rx: builds FC DLLPs with an independent
// polynomial-division CRC and checks credits, flags and pulses.
module tb_pcie_flow_ctrl_rx;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic [2:0]  s_axis_tuser;
    logic        s_axis_tready;
    logic        fc_init_en_i;
    logic        fc1_values_stored_o;
    logic        fc2_values_stored_o;
    logic [7:0]  p_hdr_o, np_hdr_o, cpl_hdr_o;
    logic [11:0] p_data_o, np_data_o, cpl_data_o;
    logic        crc_err_o;
    logic        malformed_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pcie_flow_ctrl_rx dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tkeep        (s_axis_tkeep),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tlast        (s_axis_tlast),
        .s_axis_tuser        (s_axis_tuser),
        .s_axis_tready       (s_axis_tready),
        .fc_init_en_i        (fc_init_en_i),
        .fc1_values_stored_o (fc1_values_stored_o),
        .fc2_values_stored_o (fc2_values_stored_o),
        .p_hdr_o             (p_hdr_o),
        .np_hdr_o            (np_hdr_o),
        .cpl_hdr_o           (cpl_hdr_o),
        .p_data_o            (p_data_o),
        .np_data_o           (np_data_o),
        .cpl_data_o          (cpl_data_o),
        .crc_err_o           (crc_err_o),
        .malformed_o         (malformed_o)
    );

    // CRC as remainder of (msg*x^16 + init*x^32) mod x^16+0x100B, byte0 MSB first.
    function automatic logic [15:0] ref_crc(input logic [31:0] body);
        logic [31:0] msg;
        logic [47:0] r;
        msg = {body[7:0], body[15:8], body[23:16], body[31:24]};
        r   = {msg, 16'h0000} ^ {16'hFFFF, 32'h0};
        for (int i = 47; i >= 16; i--) begin
            if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h1100B;
        end
        return r[15:0];
    endfunction

    function automatic logic [31:0] mk_fc(input logic [3:0] kind, input logic [2:0] vc,
                                          input logic [7:0] hdr, input logic [11:0] data);
        logic [7:0] b0, b1, b2, b3;
        b0 = {kind, 1'b0, vc};
        b1 = {2'b00, hdr[7:2]};
        b2 = {hdr[1:0], 2'b00, data[11:8]};
        b3 = data[7:0];
        return {b3, b2, b1, b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                        input logic [2:0] u);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Two-beat DLLP; returns just after the CRC-beat edge so outputs are fresh.
    task automatic send_dllp(input string name, input logic [31:0] body, input logic [15:0] flip);
        beat(body, 4'hF, 1'b0, 3'b001);
        beat({16'h0000, ~ref_crc(body) ^ flip}, 4'h3, 1'b1, 3'b001);
        $display("tx %s body=%08h crc_flip=%04h", name, body, flip);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i         = 1'b1;
        fc_init_en_i  = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 32'(s_axis_tready), 0);
        chk("rst_p_hdr", 32'(p_hdr_o), 0);
        chk("rst_cpl_data", 32'(cpl_data_o), 0);
        chk("rst_fc1", 32'(fc1_values_stored_o), 0);
        chk("rst_pulses", 32'({crc_err_o, malformed_o}), 0);
        rst_i = 1'b0;
        tick();
        chk("tready_after_rst", 32'(s_axis_tready), 1);

        // Bad CRC: pulse, nothing recorded
        send_dllp("InitFC1_P bad", mk_fc(4'h4, 3'd0, 8'd32, 12'd64), 16'h0001);
        chk("crc_err_pulse", 32'(crc_err_o), 1);
        chk("crc_err_p_hdr", 32'(p_hdr_o), 0);
        chk("crc_err_p_data", 32'(p_data_o), 0);
        tick();
        chk("crc_err_one_cycle", 32'(crc_err_o), 0);

        // InitFC1 sequence with duplicate P
        send_dllp("InitFC1_P", mk_fc(4'h4, 3'd0, 8'd32, 12'd64), 16'h0000);
        chk("p_hdr_32", 32'(p_hdr_o), 32);
        chk("p_data_64", 32'(p_data_o), 64);
        chk("fc1_not_yet", 32'(fc1_values_stored_o), 0);
        send_dllp("InitFC1_P dup", mk_fc(4'h4, 3'd0, 8'd8, 12'd5), 16'h0000);
        chk("p_hdr_no_overwrite", 32'(p_hdr_o), 32);
        chk("p_data_no_overwrite", 32'(p_data_o), 64);
        send_dllp("InitFC1_NP", mk_fc(4'h5, 3'd0, 8'd32, 12'd0), 16'h0000);
        chk("np_hdr_32", 32'(np_hdr_o), 32);
        chk("np_data_0", 32'(np_data_o), 0);
        chk("fc1_two_types", 32'(fc1_values_stored_o), 0);
        send_dllp("InitFC1_Cpl", mk_fc(4'h6, 3'd0, 8'd32, 12'd64), 16'h0000);
        chk("cpl_data_64", 32'(cpl_data_o), 64);
        chk("fc1_set", 32'(fc1_values_stored_o), 1);
        chk("fc2_not_yet", 32'(fc2_values_stored_o), 0);

        // UpdateFC after fc1 sets fc2; clearing enable drops everything
        send_dllp("UpdateFC_P", mk_fc(4'h8, 3'd0, 8'd40, 12'd99), 16'h0000);
        chk("fc2_set", 32'(fc2_values_stored_o), 1);
        chk("update_no_overwrite", 32'(p_hdr_o), 32);
        fc_init_en_i = 1'b0;
        tick();
        chk("clr_fc1", 32'(fc1_values_stored_o), 0);
        chk("clr_fc2", 32'(fc2_values_stored_o), 0);
        chk("clr_p_hdr", 32'(p_hdr_o), 0);
        chk("clr_cpl_data", 32'(cpl_data_o), 0);
        fc_init_en_i = 1'b1;

        // Framing errors
        beat(mk_fc(4'h4, 3'd0, 8'd1, 12'd1), 4'hF, 1'b1, 3'b001);
        $display("tx single-beat DLLP");
        chk("malformed_short", 32'(malformed_o), 1);
        tick();
        chk("malformed_one_cycle", 32'(malformed_o), 0);
        beat(mk_fc(4'h4, 3'd0, 8'd1, 12'd1), 4'hF, 1'b0, 3'b001);
        beat(32'h0000_1234, 4'h3, 1'b0, 3'b001);
        chk("malformed_long", 32'(malformed_o), 1);
        beat(32'h0000_5678, 4'h3, 1'b1, 3'b001);
        $display("tx three-beat DLLP");
        chk("drain_no_pulse", 32'({malformed_o, crc_err_o}), 0);
        chk("drain_no_store", 32'(p_hdr_o), 0);
        send_dllp("InitFC1_P after drain", mk_fc(4'h4, 3'd0, 8'd16, 12'd20), 16'h0000);
        chk("post_drain_p_hdr", 32'(p_hdr_o), 16);
        chk("post_drain_p_data", 32'(p_data_o), 20);

        // Ignored DLLPs: VC1 and non-DLLP packet
        send_dllp("InitFC1_NP vc1", mk_fc(4'h5, 3'd1, 8'd7, 12'd7), 16'h0000);
        chk("vc1_ignored", 32'(np_hdr_o), 0);
        beat(mk_fc(4'h5, 3'd0, 8'd9, 12'd9), 4'hF, 1'b0, 3'b000);
        beat({16'h0000, ~ref_crc(mk_fc(4'h5, 3'd0, 8'd9, 12'd9))}, 4'h3, 1'b1, 3'b000);
        $display("tx non-DLLP packet");
        chk("tlp_ignored", 32'(np_hdr_o), 0);
        chk("tlp_no_pulse", 32'({malformed_o, crc_err_o}), 0);

        // InitFC2 completing the set: fc1 now, fc2 one cycle later
        send_dllp("InitFC2_NP", mk_fc(4'hD, 3'd0, 8'd4, 12'd8), 16'h0000);
        chk("fc2_np_hdr", 32'(np_hdr_o), 4);
        chk("fc2_np_data", 32'(np_data_o), 8);
        send_dllp("InitFC2_Cpl", mk_fc(4'hE, 3'd0, 8'd0, 12'd128), 16'h0000);
        chk("fc2_cpl_data", 32'(cpl_data_o), 128);
        chk("fc1_via_initfc2", 32'(fc1_values_stored_o), 1);
        chk("fc2_delayed", 32'(fc2_values_stored_o), 0);
        tick();
        chk("fc2_after_delay", 32'(fc2_values_stored_o), 1);

        // Reset between beat0 and CRC beat
        beat(mk_fc(4'h4, 3'd0, 8'd50, 12'd50), 4'hF, 1'b0, 3'b001);
        rst_i = 1'b1;
        tick();
        chk("midrst_p_hdr", 32'(p_hdr_o), 0);
        chk("midrst_flags", 32'({fc1_values_stored_o, fc2_values_stored_o}), 0);
        chk("midrst_tready", 32'(s_axis_tready), 0);
        rst_i = 1'b0;
        tick();
        send_dllp("InitFC1_NP after reset", mk_fc(4'h5, 3'd0, 8'd10, 12'd30), 16'h0000);
        chk("postrst_np_hdr", 32'(np_hdr_o), 10);
        chk("postrst_np_data", 32'(np_data_o), 30);
        chk("postrst_no_malformed", 32'(malformed_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
